// File: rtl/loop_ctrl.sv
// loop_ctrl: BF loop controller; drives the loop stack for '[' / ']' and runs the forward skip-scan.
// Optional feature macro: LOOP_CTRL_HALT_ON_ERR_EN (lock into HALT on any error event).
module loop_ctrl #(
    parameter int unsigned PC_WIDTH         = 16,
    parameter int unsigned STACK_ADDR_WIDTH = 5,
    parameter int unsigned NEST_WIDTH       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      instr_valid,
    input  logic                      is_open,
    input  logic                      is_close,
    input  logic [PC_WIDTH-1:0]       cur_pc,
    input  logic                      cell_zero,
    input  logic [PC_WIDTH-1:0]       stack_top,
    output logic [PC_WIDTH-1:0]       stack_pushd,
    output logic                      stack_push_en,
    output logic                      stack_pop_en,
    output logic                      jump_en,
    output logic [PC_WIDTH-1:0]       jump_pc,
    output logic                      skip,
    output logic [STACK_ADDR_WIDTH:0] depth,
    output logic                      err
);

    localparam int unsigned DEPTH_W = STACK_ADDR_WIDTH + 1;
    localparam logic [DEPTH_W-1:0] MAX_DEPTH = {1'b1, {STACK_ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKIP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEPTH_W-1:0]    r_depth;
    logic [DEPTH_W-1:0]    w_depth_nxt;
    logic [NEST_WIDTH-1:0] r_nest;
    logic [NEST_WIDTH-1:0] w_nest_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_err_evt;

    // is_open has priority when both flags are raised
    logic w_open;
    logic w_close;
    assign w_open  = instr_valid & is_open;
    assign w_close = instr_valid & is_close & ~is_open;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_depth <= '0;
            r_nest  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_depth <= w_depth_nxt;
            r_nest  <= w_nest_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_depth_nxt = r_depth;
        w_nest_nxt  = r_nest;
        w_err_nxt   = r_err;
        w_err_evt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_open) begin
                    if (cell_zero) begin
                        w_state_nxt = ST_SKIP;
                        w_nest_nxt  = NEST_WIDTH'(1);
                    end else if (r_depth == MAX_DEPTH) begin
                        w_err_evt = 1'b1;
                    end else begin
                        w_depth_nxt = r_depth + DEPTH_W'(1);
                    end
                end else if (w_close) begin
                    if (r_depth == '0) begin
                        w_err_evt = 1'b1;
                    end else if (cell_zero) begin
                        w_depth_nxt = r_depth - DEPTH_W'(1);
                    end
                end
            end
            ST_SKIP: begin
                if (w_open) begin
                    if (r_nest == '1) begin
                        w_err_evt = 1'b1;
                    end else begin
                        w_nest_nxt = r_nest + NEST_WIDTH'(1);
                    end
                end else if (w_close) begin
                    if (r_nest == NEST_WIDTH'(1)) begin
                        w_state_nxt = ST_RUN;
                        w_nest_nxt  = '0;
                    end else begin
                        w_nest_nxt = r_nest - NEST_WIDTH'(1);
                    end
                end
            end
`ifdef LOOP_CTRL_HALT_ON_ERR_EN
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
`endif
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (w_err_evt) begin
            w_err_nxt = 1'b1;
`ifdef LOOP_CTRL_HALT_ON_ERR_EN
            w_state_nxt = ST_HALT;
`endif
        end
    end

    // Mealy outputs; forced low while reset is asserted
    always_comb begin
        stack_pushd   = '0;
        stack_push_en = 1'b0;
        stack_pop_en  = 1'b0;
        jump_en       = 1'b0;
        jump_pc       = '0;
        skip          = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (w_open && !cell_zero && (r_depth != MAX_DEPTH)) begin
                        stack_push_en = 1'b1;
                        stack_pushd   = cur_pc + PC_WIDTH'(1);
                    end else if (w_close && (r_depth != '0)) begin
                        if (cell_zero) begin
                            stack_pop_en = 1'b1;
                        end else begin
                            jump_en = 1'b1;
                            jump_pc = stack_top;
                        end
                    end
                end
                ST_SKIP: begin
                    skip = 1'b1;
                end
`ifdef LOOP_CTRL_HALT_ON_ERR_EN
                ST_HALT: begin
                    skip = 1'b1;
                end
`endif
                default: begin
                    skip = 1'b0;
                end
            endcase
        end
    end

    assign depth = r_depth;
    assign err   = r_err;

endmodule

// File: tb/tb_loop_ctrl.sv
// Scoreboard bench for loop_ctrl: a behavioural model queues expected outputs per driven cycle.
module tb_loop_ctrl;

    localparam int MAXD = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        is_open = 1'b0;
    logic        is_close = 1'b0;
    logic        cell_zero = 1'b0;
    logic [15:0] cur_pc = 16'h0;
    logic [15:0] stack_top = 16'h0;
    logic [15:0] stack_pushd;
    logic        stack_push_en;
    logic        stack_pop_en;
    logic        jump_en;
    logic [15:0] jump_pc;
    logic        skip;
    logic [5:0]  depth;
    logic        err;

    typedef struct packed {
        logic        push;
        logic        pop;
        logic        jump;
        logic [15:0] jpc;
        logic [15:0] pushd;
        logic        skip;
        logic [5:0]  depth;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state: 0 RUN, 1 SKIP, 2 HALT
    int          m_state = 0;
    int          m_depth = 0;
    int          m_nest = 0;
    logic        m_err = 1'b0;
    logic [15:0] m_stack[MAXD];

    loop_ctrl #(.PC_WIDTH(16), .STACK_ADDR_WIDTH(5), .NEST_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .is_open(is_open),
        .is_close(is_close), .cur_pc(cur_pc), .cell_zero(cell_zero), .stack_top(stack_top),
        .stack_pushd(stack_pushd), .stack_push_en(stack_push_en), .stack_pop_en(stack_pop_en),
        .jump_en(jump_en), .jump_pc(jump_pc), .skip(skip), .depth(depth), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle and queue the expected response from the model
    task automatic issue(input logic v, input logic op, input logic cl,
                         input logic [15:0] pc, input logic cz);
        exp_t e;
        logic ev;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        instr_valid = v; is_open = op; is_close = cl; cur_pc = pc; cell_zero = cz;
        stack_top = (m_depth > 0) ? m_stack[m_depth-1] : 16'h0;
        e = '0;
        e.depth = 6'(m_depth);
        e.err = m_err;
        ev = 1'b0;
        case (m_state)
            2: e.skip = 1'b1;
            1: begin
                e.skip = 1'b1;
                if (v && op) begin
                    if (m_nest == 255) ev = 1'b1;
                    else m_nest++;
                end else if (v && cl) begin
                    if (m_nest == 1) begin m_state = 0; m_nest = 0; end
                    else m_nest--;
                end
            end
            default: begin
                if (v && op) begin
                    if (cz) begin m_state = 1; m_nest = 1; end
                    else if (m_depth == MAXD) ev = 1'b1;
                    else begin
                        e.push = 1'b1;
                        e.pushd = pc + 16'd1;
                        m_stack[m_depth] = pc + 16'd1;
                        m_depth++;
                    end
                end else if (v && cl) begin
                    if (m_depth == 0) ev = 1'b1;
                    else if (cz) begin e.pop = 1'b1; m_depth--; end
                    else begin e.jump = 1'b1; e.jpc = m_stack[m_depth-1]; end
                end
            end
        endcase
        if (ev) begin
            m_err = 1'b1;
`ifdef LOOP_CTRL_HALT_ON_ERR_EN
            m_state = 2;
`endif
        end
        sb_q.push_back(e);
    endtask

    // Assert reset for one cycle with arbitrary instruction inputs present
    task automatic do_reset(input logic v, input logic op, input logic cl, input logic cz);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        instr_valid = v; is_open = op; is_close = cl; cell_zero = cz; cur_pc = 16'h0033;
        m_state = 0; m_depth = 0; m_nest = 0; m_err = 1'b0;
        sb_q.push_back('0);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check_val("push_en", 32'(stack_push_en), 32'(mon_e.push));
            check_val("pop_en",  32'(stack_pop_en),  32'(mon_e.pop));
            check_val("jump_en", 32'(jump_en),       32'(mon_e.jump));
            check_val("jump_pc", 32'(jump_pc),       32'(mon_e.jpc));
            check_val("pushd",   32'(stack_pushd),   32'(mon_e.pushd));
            check_val("skip",    32'(skip),          32'(mon_e.skip));
            check_val("depth",   32'(depth),         32'(mon_e.depth));
            check_val("err",     32'(err),           32'(mon_e.err));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        do_reset(1'b1, 1'b1, 1'b0, 1'b0);

        // Basic loop: push, back-jump, pop
        issue(1, 1, 0, 16'h0010, 0);
        issue(1, 0, 1, 16'h0018, 0);
        issue(1, 0, 1, 16'h0018, 1);
        issue(0, 0, 0, 16'h0019, 0);

        // Skip-scan over a nested body
        issue(1, 1, 0, 16'h0020, 1);
        issue(1, 1, 0, 16'h0021, 0);
        issue(1, 0, 0, 16'h0022, 0);
        issue(1, 0, 1, 16'h0023, 0);
        issue(1, 0, 1, 16'h0024, 0);
        issue(1, 0, 0, 16'h0025, 0);
        issue(0, 0, 0, 16'h0026, 0);

        // Reset in the middle of a skip at nest 3
        issue(1, 1, 0, 16'h0030, 1);
        issue(1, 1, 0, 16'h0031, 1);
        issue(1, 1, 0, 16'h0032, 1);
        do_reset(1'b1, 1'b1, 1'b0, 1'b1);
        issue(1, 1, 0, 16'h0040, 0);
        issue(1, 0, 1, 16'h0041, 1);

        // Depth overflow at 2^5 entries
        for (int i = 0; i < 33; i++) issue(1, 1, 0, 16'(16'h0100 + i), 0);
        issue(0, 0, 0, 16'h0200, 0);
        issue(1, 0, 1, 16'h0201, 0);
        issue(1, 1, 0, 16'h0202, 1);
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);

        // Underflow, then a normal push
        issue(1, 0, 1, 16'h0050, 1);
        issue(1, 1, 0, 16'h0050, 0);
        issue(0, 0, 0, 16'h0051, 0);
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);

        // PC wrap, idle with is_open, jump to wrapped target, both flags set
        issue(1, 1, 0, 16'hFFFF, 0);
        issue(0, 1, 0, 16'h1234, 0);
        issue(1, 0, 1, 16'h0005, 0);
        issue(1, 1, 1, 16'h0007, 0);
        issue(1, 0, 1, 16'h0009, 1);
        issue(1, 0, 1, 16'h000A, 1);
        issue(0, 0, 0, 16'h000B, 0);
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);

        // Nest counter saturation during skip
        issue(1, 1, 0, 16'h0300, 1);
        for (int i = 0; i < 255; i++) issue(1, 1, 0, 16'h0301, 0);
        for (int i = 0; i < 255; i++) issue(1, 0, 1, 16'h0302, 0);
        issue(1, 0, 0, 16'h0303, 0);
        issue(1, 1, 0, 16'h0304, 0);
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            issue(r != 9, (r < 3) || (r == 8), (r >= 3 && r < 6) || (r == 8),
                  16'($urandom), $urandom_range(0, 3) == 0);
        end

        @(posedge clk);
        @(posedge clk);
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
